odd_parity_serial_checker: RTL
==============================

// Module: odd_parity_serial_checker
// PURPOSE
//   Receive end of the odd-parity link. The generator side drives parity = XNOR(data bits).
//   This block takes one serial frame: DATA_W data bits LSB-first, then 1 parity bit.
//   It reassembles the data word and checks that the frame holds an odd number of ones.
//   It reports the result with a one-cycle done strobe and counts bad frames.
//   It sits between the serial bit source and the downstream consumer of data_out.
// PARAMETERS
//   DATA_W   8   number of data bits per frame (>=1); frame length = DATA_W+1
//   ERR_W    8   width of the saturating bad-frame counter
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   start       in   1        begin a new frame; 1-cycle pulse
//   bit_in      in   1        serial bit; sampled only when bit_valid=1
//   bit_valid   in   1        bit_in carries a frame bit this cycle
//   busy        out  1        high while a frame is being collected
//   done        out  1        1-cycle strobe: frame complete, result valid
//   parity_ok   out  1        1 = frame had odd number of ones; held until next done
//   data_out    out  DATA_W   reassembled data word (bit0 = first received); held until next done
//   err_count   out  ERR_W    number of frames with parity_ok=0; saturates at all-ones
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, parity_ok=0, data_out=0, err_count=0;
//     bit counter, shift register and running parity cleared. Reset mid-frame discards the frame; no done.
//   FSM states: IDLE, RECV, DONE.
//   IDLE: bit_valid ignored. start=1 -> RECV next cycle; counter=0, parity accumulator=0, busy=1.
//   RECV: each cycle with bit_valid=1 accepts bit_in. Accumulator ^= bit_in; counter++.
//     While counter<DATA_W, bit_in goes into shift reg position [counter] (LSB first).
//     The bit accepted at counter==DATA_W is the parity bit. On that edge -> DONE.
//     bit_valid=0 stalls with no change. Gaps between bits are unlimited.
//   DONE (one cycle): done=1, busy=0.
//     parity_ok = accumulator incl. parity bit (1 = odd count); data_out = shift reg.
//     If parity_ok=0, err_count += 1 unless already all-ones.
//     Next state IDLE unconditionally; start or bit_valid in DONE cycle ignored.
//   Latency: done rises 1 cycle after the edge that accepts the parity bit.
//   Minimum frame time: 1 (start) + DATA_W+1 bits + 1 (DONE) cycles.
//   start while in RECV: abort current frame; counter/accumulator/shift reg cleared.
//     Stay in RECV with no done; any bit_valid in that cycle is ignored.
//   start and bit_valid together in IDLE: start wins, the bit is dropped.
//   parity_ok/data_out change only in the DONE cycle; otherwise they hold the last frame result.
//   Counter width = clog2(DATA_W+1); no wrap is reachable because RECV exits at DATA_W.
//   DATA_W=2 check: parity_ok = NOT(XNOR3(d0,d1,p)).
// TESTING
//   1. DATA_W=8, start, bits 0,0,0,0,0,1,0,1 then parity 1 -> one-cycle done, parity_ok=1,
//      data_out=8'hA0, err_count=0.
//   2. Same data with parity 0 -> done, parity_ok=0, err_count=1.
//      Then 8'hFF with parity 1 -> parity_ok=1, err_count stays 1.
//   3. start, 4 bits, start again, full 9-bit frame 8'h01 parity 0 -> exactly one done,
//      data_out=8'h01, parity_ok=1.
//   4. Random bit_valid gaps (0-5 cycles) over 100 random frames with correct XNOR parity ->
//      every done has parity_ok=1, data_out matches, err_count=0.
//   5. rst_n low after 5 bits, release, then full frame -> no done before reset; all outputs 0
//      during reset; next frame checked correctly.
//   6. ERR_W=2, 5 bad frames -> err_count 1,2,3,3,3 (saturates).
//      DATA_W=2: all 8 (d0,d1,p) combos -> parity_ok = ~(~(d0^d1^p)).

Source files
------------

// File: rtl/odd_parity_serial_checker.sv
// Odd-parity serial frame checker.
// Collects DATA_W data bits (LSB first) followed by one parity bit, rebuilds the
// data word, and reports whether the whole frame held an odd number of ones.
// A saturating counter tracks the number of frames that failed the check.
//
// Handshake: there is no backpressure. A bit is consumed on every rising edge
// where bit_valid=1 while a frame is being collected (busy=1); bit_valid is
// ignored at all other times. start is a one-cycle pulse that opens a frame
// from IDLE, or restarts the frame being collected. done is a one-cycle strobe,
// and parity_ok/data_out/err_count are valid from that cycle until the next done.
module odd_parity_serial_checker #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic              parity_ok,
  output logic [DATA_W-1:0] data_out,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                acc_q, acc_d;
  logic                parity_ok_q, parity_ok_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                frame_par;

  // Running parity including the bit currently on the wire.
  assign frame_par = acc_q ^ bit_in;

  // Next-state and datapath update; results latch on the edge taking the parity bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    parity_ok_d = parity_ok_q;
    data_out_d  = data_out_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          cnt_d   = '0;
          acc_d   = 1'b0;
          shift_d = '0;
        end
      end
      RECV: begin
        if (start) begin
          // Restart: the partial frame is thrown away, any bit this cycle is dropped.
          cnt_d   = '0;
          acc_d   = 1'b0;
          shift_d = '0;
        end else if (bit_valid) begin
          acc_d = frame_par;
          if (cnt_q == CNT_W'(DATA_W)) begin
            // Parity bit: publish the frame result so it is visible during DONE.
            state_d     = DONE;
            parity_ok_d = frame_par;
            data_out_d  = shift_q;
            if (!frame_par && (err_q != '1)) begin
              err_d = err_q + ERR_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < DATA_W; i++) begin
              if (cnt_q == CNT_W'(i)) begin
                shift_d[i] = bit_in;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      acc_q       <= 1'b0;
      parity_ok_q <= 1'b0;
      data_out_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      parity_ok_q <= parity_ok_d;
      data_out_q  <= data_out_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q == RECV);
  assign done      = (state_q == DONE);
  assign parity_ok = parity_ok_q;
  assign data_out  = data_out_q;
  assign err_count = err_q;

endmodule
